// File: rtl/fifo_pkg.sv
// Shared constants, error-flag struct and level helper for the parametrised FIFO controller.
package fifo_pkg;

    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_ADDR_W = 3;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    // Callers zero-extend their pointers to 16 bits and truncate the result to their pointer width.
    function automatic logic [15:0] fifo_level(input logic [15:0] wptr, input logic [15:0] rptr);
        return wptr - rptr;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Dual-port register array: synchronous write, asynchronous read, no reset on contents.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_ctrl_param.sv
// Single-clock FIFO controller with level, thresholds, flush and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads have one-cycle latency.
module fifo_ctrl_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = FIFO_DATA_W,
    parameter int ADDR_W    = FIFO_ADDR_W,
    parameter int AE_THRESH = 1,
    parameter int AF_THRESH = 7
) (
    input  logic              clock,
    input  logic              rstsync,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              flush,
    input  logic              clr_err,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow,
    output logic [ADDR_W:0]   r_addr,
    output logic [ADDR_W:0]   w_addr
);

    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] AE_LVL  = PTR_W'(AE_THRESH);
    localparam logic [PTR_W-1:0] AF_LVL  = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0]  r_addr_q, r_addr_d;
    logic [PTR_W-1:0]  w_addr_q, w_addr_d;
    fifo_err_t         err_q, err_d;
    logic              empty_s, full_s;
    logic [PTR_W-1:0]  level_s;
    logic              rd_acc_s, wr_acc_s;
    logic              ovf_set_s, unf_set_s;
    logic [DATA_W-1:0] mem_rdata_s;

    // Status flags derived purely from the registered pointers.
    always_comb begin
        empty_s = (r_addr_q == w_addr_q);
        full_s  = (r_addr_q[ADDR_W-1:0] == w_addr_q[ADDR_W-1:0]) &&
                  (r_addr_q[ADDR_W] != w_addr_q[ADDR_W]);
        level_s = PTR_W'(fifo_level(16'(w_addr_q), 16'(r_addr_q)));
    end

    // Request acceptance: a full FIFO still takes a write when a read frees a slot the same cycle.
    always_comb begin
        rd_acc_s  = rd_en & ~empty_s & ~flush;
        wr_acc_s  = wr_en & ~flush & (~full_s | rd_acc_s);
        ovf_set_s = wr_en & ~flush & ~wr_acc_s;
        unf_set_s = rd_en & ~flush & empty_s;
    end

    // Next-state pointers and sticky errors; set wins over clear.
    always_comb begin
        r_addr_d = r_addr_q;
        w_addr_d = w_addr_q;
        if (flush) begin
            r_addr_d = '0;
            w_addr_d = '0;
        end else begin
            if (rd_acc_s) begin
                r_addr_d = r_addr_q + PTR_ONE;
            end else begin
                r_addr_d = r_addr_q;
            end
            if (wr_acc_s) begin
                w_addr_d = w_addr_q + PTR_ONE;
            end else begin
                w_addr_d = w_addr_q;
            end
        end
        err_d.overflow  = ovf_set_s | (err_q.overflow  & ~clr_err);
        err_d.underflow = unf_set_s | (err_q.underflow & ~clr_err);
    end

    // Pointer and error-flag state.
    always_ff @(posedge clock or negedge rstsync) begin
        if (!rstsync) begin
            r_addr_q <= '0;
            w_addr_q <= '0;
            err_q    <= '0;
        end else begin
            r_addr_q <= r_addr_d;
            w_addr_q <= w_addr_d;
            err_q    <= err_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (clock),
        .we_i    (wr_acc_s),
        .waddr_i (w_addr_q[ADDR_W-1:0]),
        .wdata_i (wr_data),
        .raddr_i (r_addr_q[ADDR_W-1:0]),
        .rdata_o (mem_rdata_s)
    );

`ifdef FIFO_FWFT_EN
    assign rd_data  = mem_rdata_s;
    assign rd_valid = ~empty_s;
`else
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    // Read-port next state: data captured on an accepted pop, held otherwise.
    always_comb begin
        if (rd_acc_s) begin
            rd_data_d = mem_rdata_s;
        end else begin
            rd_data_d = rd_data_q;
        end
        rd_valid_d = rd_acc_s;
    end

    // Registered read port.
    always_ff @(posedge clock or negedge rstsync) begin
        if (!rstsync) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

    assign empty        = empty_s;
    assign full         = full_s;
    assign level        = level_s;
    assign almost_empty = (level_s <= AE_LVL);
    assign almost_full  = (level_s >= AF_LVL);
    assign overflow     = err_q.overflow;
    assign underflow    = err_q.underflow;
    assign r_addr       = r_addr_q;
    assign w_addr       = w_addr_q;

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Scoreboard bench for fifo_ctrl_param: a queue model of contents plus expected-read queue.
module tb_fifo_ctrl_param;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clock = 1'b0;
    logic          rstsync = 1'b0;
    logic          wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0, clr_err = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid, empty, full, almost_empty, almost_full, overflow, underflow;
    logic [AW:0]   level, r_addr, w_addr;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            m_r = 0, m_w = 0;
    bit            m_ovf = 0, m_unf = 0, m_rdv = 0;

    fifo_ctrl_param #(.DATA_W(DW), .ADDR_W(AW), .AE_THRESH(1), .AF_THRESH(7)) dut (
        .clock(clock), .rstsync(rstsync), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .flush(flush),
        .clr_err(clr_err), .empty(empty), .full(full), .almost_empty(almost_empty),
        .almost_full(almost_full), .level(level), .overflow(overflow),
        .underflow(underflow), .r_addr(r_addr), .w_addr(w_addr)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_status();
        int lvl;
        lvl = fifo_q.size();
        check_val("level", 32'(level), 32'(lvl));
        check_val("empty", 32'(empty), 32'(lvl == 0));
        check_val("full", 32'(full), 32'(lvl == DEPTH));
        check_val("almost_empty", 32'(almost_empty), 32'(lvl <= 1));
        check_val("almost_full", 32'(almost_full), 32'(lvl >= 7));
        check_val("overflow", 32'(overflow), 32'(m_ovf));
        check_val("underflow", 32'(underflow), 32'(m_unf));
        check_val("r_addr", 32'(r_addr), 32'(m_r));
        check_val("w_addr", 32'(w_addr), 32'(m_w));
    endtask

    task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re,
                         input logic fl, input logic ce);
        bit empty_m, full_m, racc, wacc;
        @(negedge clock);
        wr_en = we; wr_data = wd; rd_en = re; flush = fl; clr_err = ce;
        empty_m = (fifo_q.size() == 0);
        full_m  = (fifo_q.size() == DEPTH);
        racc    = re && !empty_m && !fl;
        wacc    = we && !fl && (!full_m || racc);
        if (racc) exp_q.push_back(fifo_q.pop_front());
`ifdef FIFO_FWFT_EN
        #1;
        check_val("fwft_valid", 32'(rd_valid), 32'(!empty_m));
        if (racc) check_val("fwft_head", 32'(rd_data), 32'(exp_q.pop_front()));
`endif
        if (racc) m_r = (m_r + 1) % 16;
        if (wacc) begin
            fifo_q.push_back(wd);
            m_w = (m_w + 1) % 16;
        end
        if (fl) begin
            fifo_q.delete();
            m_r = 0;
            m_w = 0;
        end
        m_ovf = (we && !fl && !wacc) ? 1'b1 : (ce ? 1'b0 : m_ovf);
        m_unf = (re && !fl && empty_m) ? 1'b1 : (ce ? 1'b0 : m_unf);
        m_rdv = racc;
        @(posedge clock);
        #1;
        check_status();
`ifndef FIFO_FWFT_EN
        check_val("rd_valid", 32'(rd_valid), 32'(m_rdv));
        if (exp_q.size() > 0) check_val("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
`else
        check_val("fwft_valid_post", 32'(rd_valid), 32'(fifo_q.size() != 0));
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_r_addr"}, 32'(r_addr), 32'd0);
        check_val({tag, "_w_addr"}, 32'(w_addr), 32'd0);
        check_val({tag, "_level"}, 32'(level), 32'd0);
        check_val({tag, "_empty"}, 32'(empty), 32'd1);
        check_val({tag, "_full"}, 32'(full), 32'd0);
        check_val({tag, "_ae"}, 32'(almost_empty), 32'd1);
        check_val({tag, "_af"}, 32'(almost_full), 32'd0);
        check_val({tag, "_ovf"}, 32'(overflow), 32'd0);
        check_val({tag, "_unf"}, 32'(underflow), 32'd0);
        check_val({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
`ifndef FIFO_FWFT_EN
        check_val({tag, "_rd_data"}, 32'(rd_data), 32'd0);
`endif
    endtask

    initial begin
        logic [DW-1:0] d;
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("por");
        @(negedge clock);
        rstsync = 1'b1;

        // 1: fill to full
        for (int i = 0; i < 8; i++) begin
            d = 8'h11 + 8'(i);
            cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
        end

        // 2: overflow, set-wins, then clear
        cycle(1'b1, 8'h19, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h19, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // 3: simultaneous read/write while full
        cycle(1'b1, 8'h20, 1'b1, 1'b0, 1'b0);

        // 4: drain and one extra read
        for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // 5: flush at level 5 with both requests
        for (int i = 0; i < 5; i++) begin
            d = 8'h30 + 8'(i);
            cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
        end
        cycle(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // 6: asynchronous reset at level 3, then wrap both pointers
        for (int i = 0; i < 3; i++) begin
            d = 8'h40 + 8'(i);
            cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clock);
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
        #2 rstsync = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        fifo_q.delete();
        exp_q.delete();
        m_r = 0; m_w = 0; m_ovf = 0; m_unf = 0; m_rdv = 0;
        @(negedge clock);
        rstsync = 1'b1;
        cycle(1'b1, 8'h60, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 20; i++) begin
            d = 8'h60 + 8'(i);
            cycle(1'b1, d, 1'b1, 1'b0, 1'b0);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl_param.md
Name: fifo_ctrl_param

Overview:
Parametrised successor to the lab FIFO read/write controller: a synchronous single-clock FIFO with integrated storage and independent read/write request ports, so a read and a write can complete in the same cycle. Adds level reporting, almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. Sits between the user-input front end (mode/button decode) and the datapath that consumes buffered operands.

Parameters:
DATA_W, 8, width of each stored word
ADDR_W, 3, log2 of depth (depth = 2**ADDR_W, default 8 entries)
AE_THRESH, 1, almost_empty asserted when level <= AE_THRESH
AF_THRESH, 7, almost_full asserted when level >= AF_THRESH

Ports:
clock  in  1  rising-edge clock
rstsync  in  1  asynchronous active-low reset
wr_en  in  1  write request
wr_data  in  DATA_W  write data
rd_en  in  1  read (pop) request
rd_data  out  DATA_W  read data
rd_valid  out  1  rd_data valid qualifier
flush  in  1  synchronous clear of FIFO contents
clr_err  in  1  clears sticky error flags
empty  out  1  no stored entries
full  out  1  2**ADDR_W stored entries
almost_empty  out  1  level <= AE_THRESH
almost_full  out  1  level >= AF_THRESH
level  out  ADDR_W+1  current entry count, 0..2**ADDR_W
overflow  out  1  sticky: write attempted while full and not accepted
underflow  out  1  sticky: read attempted while empty
r_addr  out  ADDR_W+1  read pointer (MSB is the wrap bit)
w_addr  out  ADDR_W+1  write pointer (MSB is the wrap bit)

Behaviour:
- Reset (rstsync=0, asynchronous): r_addr=0, w_addr=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Therefore empty=1, full=0, level=0, almost_empty=1, almost_full=0. Memory contents are not reset.
- empty = (r_addr == w_addr). full = low ADDR_W bits equal and MSBs differ. level = w_addr - r_addr modulo 2**(ADDR_W+1). All flags are combinational from registered pointers.
- rd_acc = rd_en & ~empty & ~flush.
- wr_acc = wr_en & ~flush & (~full | rd_acc). A write into a full FIFO is accepted when a read is accepted in the same cycle.
- Accepted write: mem[w_addr[ADDR_W-1:0]] <= wr_data; w_addr increments, wrapping modulo 2**(ADDR_W+1).
- Accepted read: r_addr increments, same wrap rule.
- Simultaneous accepted read and write: level is unchanged. When empty, the read is rejected and the write is accepted.
- Non-FWFT read latency: rd_data <= mem[r_addr] and rd_valid <= 1 on the edge that accepts the read. rd_valid otherwise returns to 0 and rd_data holds its last value.
- overflow is set when wr_en & ~flush & ~wr_acc. underflow is set when rd_en & ~flush & empty.
- clr_err clears both error flags. If a set condition and clr_err occur in the same cycle, set wins.
- flush: both pointers go to 0 and rd_valid goes to 0 next edge. Same-cycle rd_en/wr_en are ignored and raise no error flags. Error flags are unaffected.
- Reset asserted mid-operation: immediate return to reset values. Data in flight is discarded.

Optional Feature:
FIFO_FWFT_EN.
- Defined: first-word-fall-through. rd_data = mem[r_addr[ADDR_W-1:0]] combinationally and rd_valid = ~empty. rd_en acts as a pop acknowledging the displayed word. Zero read latency.
- Undefined: registered-read behaviour as above, one-cycle latency.
- Flags, pointers and errors are identical in both builds.

Decomposition:
- Shared package fifo_pkg holds:
  - default constants FIFO_DATA_W=8 and FIFO_ADDR_W=3;
  - a packed struct fifo_err_t {overflow, underflow};
  - a function fifo_level(wptr, rptr).
- One sub-module, fifo_mem: dual-port register array with synchronous write and asynchronous read, parametrised by DATA_W and ADDR_W.
- Pointer/flag/error logic stays in fifo_ctrl_param.

Test Plan:
1. Reset, then write 0x11..0x18 (8 writes) -> full=1, level=8, almost_full=1 from the 7th write; w_addr=8 (wrap bit set), r_addr=0.
2. Full, 9th write 0x19 with rd_en=0 -> write rejected, overflow=1, level stays 8. Then clr_err -> overflow=0.
3. Full, wr_en=1 with 0x20 and rd_en=1 in the same cycle -> level stays 8, 0x11 popped, 0x20 stored at index 0, w_addr=9.
4. Drain all entries, then rd_en once more -> non-FWFT: rd_valid pulses with 0x12..0x18, 0x20 in order, one cycle after each pop; the extra read sets underflow=1 and rd_valid=0. Same sequence with FIFO_FWFT_EN: rd_data shows the head before rd_en.
5. Level 5, assert flush with wr_en=1 and rd_en=1 -> next edge level=0, empty=1, no new error flags, no write stored.
6. Level 3, deassert rstsync between clock edges -> outputs go to reset values immediately. Run 20 write/read cycles after release -> correct wrap of both pointers through 15->0.
